branch_ctrl: RTL and testbench

Parametrised branch/flag controller for the 9-bit core; the successor to the combinational branch decoder. It latches ALU condition flags on compare instructions and evaluates an 8-way condition field on branch instructions against the latched flags. A taken branch produces a registered branch_en pulse plus a LUT index to the fetch unit, then squashes the wrong-path instructions for a programmable number of cycles. A saturating counter records taken branches.

---
 rtl/branch_ctrl.sv | 116 +++++++++++
 tb/tb_branch_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch/flag controller: latches ALU flags on CMP, evaluates conditional
// branches against them, pulses branch_en and squashes wrong-path fetches.
module branch_ctrl #(
    parameter int unsigned         INSTR_W      = 9,
    parameter int unsigned         OP_W         = 3,
    parameter logic [OP_W-1:0]     OP_CMP       = 3'b110,
    parameter logic [OP_W-1:0]     OP_BR        = 3'b111,
    parameter int unsigned         LUT_W        = 3,
    parameter int unsigned         FLUSH_CYCLES = 2,
    parameter int unsigned         CNT_W        = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               instr_valid,
    input  logic               ZERO,
    input  logic               BEVEN,
    input  logic               NEG,
    input  logic               CARRY,
    output logic               branch_en,
    output logic [LUT_W-1:0]   lut_idx,
    output logic               flush,
    output logic [3:0]         flags_q,
    output logic [CNT_W-1:0]   taken_count
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic [3:0]          flags_d;
    logic                be_q, be_d;
    logic [LUT_W-1:0]    lut_q, lut_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [OP_W-1:0]     opcode;
    logic [2:0]          cond;
    logic                cond_true;
    logic                accept;

    always_comb begin
        opcode    = Instruction[INSTR_W-1 -: OP_W];
        cond      = Instruction[INSTR_W-OP_W-1 -: 3];
        accept    = instr_valid && (state_q == RUN);
        cond_true = 1'b0;
        // flags_q layout is {C, N, E, Z}
        unique case (cond)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = flags_q[0];
            3'd2: cond_true = !flags_q[0];
            3'd3: cond_true = flags_q[1];
            3'd4: cond_true = !flags_q[1];
            3'd5: cond_true = flags_q[2];
            3'd6: cond_true = !flags_q[2];
            3'd7: cond_true = flags_q[3];
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        flags_d = flags_q;
        be_d    = 1'b0;
        lut_d   = lut_q;
        cnt_d   = cnt_q;
        flush   = (state_q == FLUSH);

        if (state_q == FLUSH) begin
            fcnt_d = fcnt_q - FC_W'(1);
            if (fcnt_q == FC_W'(1)) begin
                state_d = RUN;
            end
        end else if (accept) begin
            if (opcode == OP_CMP) begin
                flags_d = {CARRY, NEG, BEVEN, ZERO};
            end else if (opcode == OP_BR && cond_true) begin
                be_d    = 1'b1;
                lut_d   = Instruction[LUT_W-1:0];
                fcnt_d  = FC_W'(FLUSH_CYCLES);
                state_d = FLUSH;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            flags_q <= '0;
            be_q    <= 1'b0;
            lut_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            flags_q <= flags_d;
            be_q    <= be_d;
            lut_q   <= lut_d;
            cnt_q   <= cnt_d;
        end
    end

    assign branch_en   = be_q;
    assign lut_idx     = lut_q;
    assign taken_count = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a behavioural model queues the expected
// post-edge outputs for each driven cycle; they are checked after the edge.
module tb_branch_ctrl;

    localparam logic [2:0] CMP = 3'b110;
    localparam logic [2:0] BR  = 3'b111;
    localparam logic [2:0] C_ALWAYS = 3'd0, C_EQ = 3'd1, C_NE = 3'd2;

    logic       Clk;
    logic       Reset;
    logic [8:0] Instruction;
    logic       instr_valid;
    logic       ZERO, BEVEN, NEG, CARRY;

    logic       branch_en, branch_en2;
    logic [2:0] lut_idx, lut_idx2;
    logic       flush, flush2;
    logic [3:0] flags_q, flags_q2;
    logic [7:0] taken_count;
    logic [1:0] taken_count2;

    branch_ctrl #(.CNT_W(8)) u_dut (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .instr_valid(instr_valid),
        .ZERO(ZERO), .BEVEN(BEVEN), .NEG(NEG), .CARRY(CARRY),
        .branch_en(branch_en), .lut_idx(lut_idx), .flush(flush),
        .flags_q(flags_q), .taken_count(taken_count)
    );

    // Narrow counter instance, same stimulus, to exercise saturation quickly.
    branch_ctrl #(.CNT_W(2)) u_dut_sat (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .instr_valid(instr_valid),
        .ZERO(ZERO), .BEVEN(BEVEN), .NEG(NEG), .CARRY(CARRY),
        .branch_en(branch_en2), .lut_idx(lut_idx2), .flush(flush2),
        .flags_q(flags_q2), .taken_count(taken_count2)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic       be;
        logic [2:0] lut;
        logic       fl;
        logic [3:0] flags;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t sb[$];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model state
    logic [3:0] m_flags = '0;
    logic [2:0] m_lut   = '0;
    logic       m_be    = 1'b0;
    logic [7:0] m_cnt   = '0;
    logic [1:0] m_cnt2  = '0;
    int         m_squash_left = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] mk(input logic [2:0] op, input logic [2:0] c, input logic [2:0] idx);
        return {op, c, idx};
    endfunction

    function automatic logic m_taken(input logic [2:0] c, input logic [3:0] f);
        logic z, e, n, cy;
        {cy, n, e, z} = f;
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return e;
            3'd4: return !e;
            3'd5: return n;
            3'd6: return !n;
            default: return cy;
        endcase
    endfunction

    task automatic step(input logic rst, input logic vld, input logic [8:0] ins, input logic [3:0] alu);
        exp_t e;
        @(negedge Clk);
        Reset       = rst;
        instr_valid = vld;
        Instruction = ins;
        {CARRY, NEG, BEVEN, ZERO} = alu;

        if (rst) begin
            m_flags = '0; m_lut = '0; m_be = 1'b0; m_cnt = '0; m_cnt2 = '0; m_squash_left = 0;
        end else begin
            m_be = 1'b0;
            if (m_squash_left > 0) begin
                m_squash_left--;
            end else if (vld) begin
                if (ins[8:6] == CMP) begin
                    m_flags = alu;
                end else if (ins[8:6] == BR && m_taken(ins[5:3], m_flags)) begin
                    m_be  = 1'b1;
                    m_lut = ins[2:0];
                    m_squash_left = 2;
                    if (m_cnt  != 8'hFF) m_cnt++;
                    if (m_cnt2 != 2'd3)  m_cnt2++;
                end
            end
        end
        e.be = m_be; e.lut = m_lut; e.fl = (m_squash_left > 0);
        e.flags = m_flags; e.cnt = m_cnt; e.cnt2 = m_cnt2;
        sb.push_back(e);

        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("branch_en",    32'(branch_en),    32'(e.be));
            check("lut_idx",      32'(lut_idx),      32'(e.lut));
            check("flush",        32'(flush),        32'(e.fl));
            check("flags_q",      32'(flags_q),      32'(e.flags));
            check("taken_count",  32'(taken_count),  32'(e.cnt));
            check("taken_count2", 32'(taken_count2), 32'(e.cnt2));
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 9'h000, 4'h0);
    endtask

    initial begin
        Reset = 1'b1; instr_valid = 1'b0; Instruction = '0;
        {CARRY, NEG, BEVEN, ZERO} = '0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom), 9'($urandom), 4'($urandom));

        // CMP Z=1,E=1 then taken BR EQ idx 5
        step(1'b0, 1'b1, mk(CMP, 3'd0, 3'd0), 4'b0011);
        step(1'b0, 1'b1, mk(BR, C_EQ, 3'd5), 4'b0000);
        idle(3);

        // Not-taken EQ then taken NE
        step(1'b0, 1'b1, mk(CMP, 3'd0, 3'd0), 4'b0000);
        step(1'b0, 1'b1, mk(BR, C_EQ, 3'd4), 4'b0000);
        idle(1);
        step(1'b0, 1'b1, mk(CMP, 3'd0, 3'd0), 4'b0000);
        step(1'b0, 1'b1, mk(BR, C_NE, 3'd2), 4'b0000);
        idle(3);

        // Instructions presented during flush are ignored
        step(1'b0, 1'b1, mk(BR, C_ALWAYS, 3'd7), 4'b0000);
        step(1'b0, 1'b1, mk(CMP, 3'd0, 3'd0), 4'b0101);
        step(1'b0, 1'b1, mk(BR, C_ALWAYS, 3'd1), 4'b0000);
        idle(2);

        // Saturation of the 2-bit counter: 1,2,3,3,3
        step(1'b1, 1'b0, 9'h000, 4'h0);
        for (int unsigned k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, mk(BR, C_ALWAYS, 3'(k)), 4'b0000);
            idle(2);
        end

        // Reset in the first flush cycle, then a normal taken branch
        step(1'b0, 1'b1, mk(BR, C_ALWAYS, 3'd6), 4'b0000);
        step(1'b1, 1'b1, mk(BR, C_ALWAYS, 3'd3), 4'b0000);
        step(1'b0, 1'b1, mk(BR, C_ALWAYS, 3'd3), 4'b0000);
        idle(3);
        // BR with instr_valid low does nothing
        step(1'b0, 1'b0, mk(BR, C_ALWAYS, 3'd2), 4'b0000);
        idle(1);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            case ($urandom_range(0, 3))
                0, 1: op = BR;
                2:    op = CMP;
                default: op = 3'($urandom);
            endcase
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 mk(op, 3'($urandom), 3'($urandom)), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
